duck_motion: RTL and testbench

Per-duck flight controller. Consumes the 8-bit pseudo-random stream of the `lfsr_updown` stage and paces that stage through its own `rng_enable` output. Runs one duck through spawn delay, flight, shot-fall and escape, and drives the sprite position to the renderer. Reports the outcome to the score/round logic.

---
 rtl/duck_pkg.sv | 20 ++
 rtl/duck_axis.sv | 40 ++++
 rtl/duck_motion.sv | 219 +++++++++++++++++++++
 tb/tb_duck_motion.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// Shared types and screen geometry defaults for the duck flight controller.
package duck_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int DUCK_W_DEF   = 64;
  localparam int DUCK_H_DEF   = 64;

  // Row where a duck appears: sprite bottom resting on the screen bottom.
  localparam int SPAWN_Y = SCREEN_H_DEF - DUCK_H_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_FLY,
    ST_FALL,
    ST_ESCAPE
  } state_t;

endpackage

// File: rtl/duck_axis.sv
// One motion axis: step a position toward 0 or the limit, bouncing off
// either bound. Math is done one bit wider so wrap-around is visible.
module duck_axis #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_pos,
  input  logic         i_dir,   // 1 = increasing coordinate
  input  logic [W-1:0] i_step,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_pos,
  output logic         o_dir
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  // Clamp-and-bounce: touching or crossing a bound parks on it and reverses.
  always_comb begin
    w_sum  = {1'b0, i_pos} + {1'b0, i_step};
    w_diff = {1'b0, i_pos} - {1'b0, i_step};
    o_pos  = i_pos;
    o_dir  = i_dir;
    if (i_dir) begin
      if (w_sum >= {1'b0, i_limit}) begin
        o_pos = i_limit;
        o_dir = 1'b0;
      end else begin
        o_pos = w_sum[W-1:0];
      end
    end else begin
      if (w_diff[W] || (w_diff == '0)) begin
        o_pos = '0;
        o_dir = 1'b1;
      end else begin
        o_pos = w_diff[W-1:0];
      end
    end
  end

endmodule

// File: rtl/duck_motion.sv
// Per-duck flight controller: spawn delay, flight with wall bounces,
// shot fall and escape. Paces the LFSR through rng_enable and reports
// the outcome of each duck as a one-cycle pulse.
module duck_motion
  import duck_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int DUCK_W     = DUCK_W_DEF,
  parameter int DUCK_H     = DUCK_H_DEF,
  parameter int SPEED      = 2,
  parameter int FALL_SPEED = 4,
  parameter int MAX_FRAMES = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hit,
  input  logic [7:0] rnd,
  output logic       rng_enable,
  output logic [9:0] duck_x,
  output logic [8:0] duck_y,
  output logic       duck_active,
  output logic       duck_falling,
  output logic       duck_down,
  output logic       duck_escaped,
  output logic       busy
);

  localparam logic [9:0] X_LIM  = 10'(SCREEN_W - DUCK_W);
  localparam logic [8:0] Y_LIM  = 9'(SCREEN_H - DUCK_H);
  localparam logic [9:0] SPD_X  = 10'(SPEED);
  localparam logic [8:0] SPD_Y  = 9'(SPEED);
  localparam logic [9:0] FALL_W = 10'(FALL_SPEED);
  localparam int FW = ($clog2(MAX_FRAMES + 1) > 5) ? $clog2(MAX_FRAMES + 1) : 5;
  localparam logic [FW-1:0] FRAMES_END = FW'(MAX_FRAMES);

  state_t        r_state;
  logic [6:0]    r_delay;
  logic [FW-1:0] r_frames;
  logic          r_dir_x;
  logic          r_dir_y;
  logic [9:0]    r_x;
  logic [8:0]    r_y;
  logic          r_active;
  logic          r_falling;
  logic          r_down;
  logic          r_escaped;
  logic          r_busy;
  logic          r_rng_en;

  state_t        w_state_nxt;
  logic [6:0]    w_delay_nxt;
  logic [FW-1:0] w_frames_nxt;
  logic [FW-1:0] w_frames_inc;
  logic          w_dir_x_nxt;
  logic          w_dir_y_nxt;
  logic [9:0]    w_x_nxt;
  logic [8:0]    w_y_nxt;
  logic          w_active_nxt;
  logic          w_falling_nxt;
  logic          w_down_nxt;
  logic          w_escaped_nxt;
  logic [9:0]    w_fall_sum;

  logic [9:0]    w_ax_x;
  logic          w_ax_dir_x;
  logic [8:0]    w_ax_y;
  logic          w_ax_dir_y;

  duck_axis #(.W(10)) u_axis_x (
    .i_pos   (r_x),
    .i_dir   (r_dir_x),
    .i_step  (SPD_X),
    .i_limit (X_LIM),
    .o_pos   (w_ax_x),
    .o_dir   (w_ax_dir_x)
  );

  duck_axis #(.W(9)) u_axis_y (
    .i_pos   (r_y),
    .i_dir   (r_dir_y),
    .i_step  (SPD_Y),
    .i_limit (Y_LIM),
    .o_pos   (w_ax_y),
    .o_dir   (w_ax_dir_y)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_delay_nxt   = r_delay;
    w_frames_nxt  = r_frames;
    w_dir_x_nxt   = r_dir_x;
    w_dir_y_nxt   = r_dir_y;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_active_nxt  = r_active;
    w_falling_nxt = r_falling;
    w_down_nxt    = 1'b0;
    w_escaped_nxt = 1'b0;
    w_frames_inc  = r_frames + 1'b1;
    w_fall_sum    = {1'b0, r_y} + FALL_W;

    unique case (r_state)
      ST_IDLE: begin
        // A start landing on an outcome pulse is dropped so the round
        // logic sees the outcome before a new duck launches.
        if (start && !r_down && !r_escaped) begin
          w_state_nxt = ST_DELAY;
          w_delay_nxt = {1'b0, rnd[5:0]} + 7'd16;
        end
      end
      ST_DELAY: begin
        if (frame_tick) begin
          if (r_delay <= 7'd1) begin
            w_state_nxt  = ST_FLY;
            w_delay_nxt  = '0;
            w_x_nxt      = {1'b0, rnd[7:1], 2'b00};
            w_y_nxt      = Y_LIM;
            w_dir_x_nxt  = rnd[0];
            w_dir_y_nxt  = 1'b0;
            w_frames_nxt = '0;
            w_active_nxt = 1'b1;
          end else begin
            w_delay_nxt = r_delay - 7'd1;
          end
        end
      end
      ST_FLY: begin
        // A hit outranks both the motion step and the timeout.
        if (hit) begin
          w_state_nxt   = ST_FALL;
          w_falling_nxt = 1'b1;
        end else if (frame_tick) begin
          w_frames_nxt = w_frames_inc;
          w_x_nxt      = w_ax_x;
          w_y_nxt      = w_ax_y;
          w_dir_y_nxt  = w_ax_dir_y;
          w_dir_x_nxt  = w_ax_dir_x ^ ((w_frames_inc[4:0] == 5'd0) && rnd[3]);
          if (w_frames_inc == FRAMES_END) begin
            w_state_nxt = ST_ESCAPE;
          end
        end
      end
      ST_FALL: begin
        if (frame_tick) begin
          if (w_fall_sum >= {1'b0, Y_LIM}) begin
            w_y_nxt       = Y_LIM;
            w_down_nxt    = 1'b1;
            w_active_nxt  = 1'b0;
            w_falling_nxt = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_y_nxt = w_fall_sum[8:0];
          end
        end
      end
      ST_ESCAPE: begin
        if (frame_tick) begin
          if (r_y <= SPD_Y) begin
            w_y_nxt       = '0;
            w_escaped_nxt = 1'b1;
            w_active_nxt  = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_y_nxt = r_y - SPD_Y;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; the LFSR free-runs while waiting for a
  // launch and steps once per frame while a duck is on screen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_delay   <= '0;
      r_frames  <= '0;
      r_dir_x   <= 1'b0;
      r_dir_y   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_active  <= 1'b0;
      r_falling <= 1'b0;
      r_down    <= 1'b0;
      r_escaped <= 1'b0;
      r_busy    <= 1'b0;
      r_rng_en  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_delay   <= w_delay_nxt;
      r_frames  <= w_frames_nxt;
      r_dir_x   <= w_dir_x_nxt;
      r_dir_y   <= w_dir_y_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_active  <= w_active_nxt;
      r_falling <= w_falling_nxt;
      r_down    <= w_down_nxt;
      r_escaped <= w_escaped_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_rng_en  <= ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DELAY)) ? 1'b1 : frame_tick;
    end
  end

  assign rng_enable   = r_rng_en;
  assign duck_x       = r_x;
  assign duck_y       = r_y;
  assign duck_active  = r_active;
  assign duck_falling = r_falling;
  assign duck_down    = r_down;
  assign duck_escaped = r_escaped;
  assign busy         = r_busy;

endmodule

// File: tb/tb_duck_motion.sv
// Directed bench for duck_motion. Spawn/landing/escape events are
// matched against an expectation queue by a free-running monitor;
// intermediate positions and control outputs are checked inline.
module tb_duck_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic [7:0] rnd = 8'h00;
  logic       rng_enable;
  logic [9:0] duck_x;
  logic [8:0] duck_y;
  logic       duck_active;
  logic       duck_falling;
  logic       duck_down;
  logic       duck_escaped;
  logic       busy;

  // event kinds: 0 spawn, 1 landed, 2 escaped
  typedef struct {
    int kind;
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_active = 1'b0;

  duck_motion dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .hit          (hit),
    .rnd          (rnd),
    .rng_enable   (rng_enable),
    .duck_x       (duck_x),
    .duck_y       (duck_y),
    .duck_active  (duck_active),
    .duck_falling (duck_falling),
    .duck_down    (duck_down),
    .duck_escaped (duck_escaped),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_evt(input int kind, input int x, input int y);
    exp_t e;
    e.kind = kind;
    e.x = x;
    e.y = y;
    exp_q.push_back(e);
  endtask

  // one frame_tick pulse, then one idle cycle; returns on a negedge
  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, int'(duck_x), 0);
    chk({tag, "_y"}, int'(duck_y), 0);
    chk({tag, "_active"}, int'(duck_active), 0);
    chk({tag, "_falling"}, int'(duck_falling), 0);
    chk({tag, "_down"}, int'(duck_down), 0);
    chk({tag, "_escaped"}, int'(duck_escaped), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rng_en"}, int'(rng_enable), 0);
  endtask

  // Monitor: every spawn edge or outcome pulse consumes one expectation.
  always @(negedge clk) begin
    int   kind;
    exp_t e;
    if (reset) begin
      prev_active <= 1'b0;
    end else begin
      kind = -1;
      if (duck_down) kind = 1;
      else if (duck_escaped) kind = 2;
      else if (duck_active && !prev_active) kind = 0;
      prev_active <= duck_active;
      if (kind >= 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("evt_kind", kind, e.kind);
          chk("evt_x", int'(duck_x), e.x);
          chk("evt_y", int'(duck_y), e.y);
        end
      end
    end
  end

  initial begin
    // ---- reset state ----
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rng_en", int'(rng_enable), 1);
    chk("idle_busy", int'(busy), 0);

    // ---- spawn: rnd=A5 -> delay 53, x=328, dir right ----
    rnd = 8'hA5;
    pulse_start();
    chk("start_busy", int'(busy), 1);
    pulse_hit();
    chk("hit_in_delay_falling", int'(duck_falling), 0);
    chk("hit_in_delay_active", int'(duck_active), 0);
    chk("hit_in_delay_busy", int'(busy), 1);
    tick_n(52);
    chk("pre_spawn_active", int'(duck_active), 0);
    expect_evt(0, 328, 416);
    tick_n(1);
    chk("spawn_active", int'(duck_active), 1);
    tick_n(1);
    chk("first_step_x", int'(duck_x), 330);
    chk("first_step_y", int'(duck_y), 414);
    // shot at the bottom: one tick lands it; start in the landing cycle dropped
    pulse_hit();
    chk("fall_flag", int'(duck_falling), 1);
    expect_evt(1, 330, 416);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("down_pulse", int'(duck_down), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_down_busy", int'(busy), 0);
    chk("down_single_cycle", int'(duck_down), 0);

    // ---- right wall and hit-with-tick: rnd=FF -> delay 79, x=508 right ----
    rnd = 8'hFF;
    pulse_start();
    chk("restart_busy", int'(busy), 1);
    expect_evt(0, 508, 416);
    tick_n(79);
    rnd = 8'h00;
    pulse_start();
    chk("start_in_fly_active", int'(duck_active), 1);
    chk("start_in_fly_x", int'(duck_x), 508);
    tick_n(33);
    chk("wall_pre_x", int'(duck_x), 574);
    chk("wall_pre_y", int'(duck_y), 350);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("wall_x", int'(duck_x), 576);
    chk("fly_rng_en_after_tick", int'(rng_enable), 1);
    @(negedge clk);
    chk("fly_rng_en_idle", int'(rng_enable), 0);
    tick_n(1);
    chk("wall_bounce_x", int'(duck_x), 574);
    chk("wall_bounce_y", int'(duck_y), 346);
    tick_n(73);
    chk("pre_hit_x", int'(duck_x), 428);
    chk("pre_hit_y", int'(duck_y), 200);
    hit = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    frame_tick = 1'b0;
    chk("hit_tick_y", int'(duck_y), 200);
    chk("hit_tick_x", int'(duck_x), 428);
    chk("hit_tick_falling", int'(duck_falling), 1);
    expect_evt(1, 428, 416);
    tick_n(53);
    chk("fall_53_y", int'(duck_y), 412);
    chk("fall_53_active", int'(duck_active), 1);
    tick_n(1);
    chk("landed_active", int'(duck_active), 0);
    chk("landed_busy", int'(busy), 0);

    // ---- timeout: rnd=00 -> delay 16, x=0 left, no dir toggles ----
    pulse_start();
    expect_evt(0, 0, 416);
    tick_n(16);
    tick_n(599);
    chk("fly599_x", int'(duck_x), 44);
    chk("fly599_y", int'(duck_y), 50);
    tick_n(1);
    chk("fly600_x", int'(duck_x), 46);
    chk("fly600_y", int'(duck_y), 48);
    tick_n(1);
    chk("escape_x_frozen", int'(duck_x), 46);
    chk("escape_y", int'(duck_y), 46);
    tick_n(22);
    chk("escape_pre_y", int'(duck_y), 2);
    chk("escape_pre_active", int'(duck_active), 1);
    expect_evt(2, 46, 0);
    tick_n(1);
    chk("escaped_busy", int'(busy), 0);
    chk("escaped_active", int'(duck_active), 0);

    // ---- reset mid-fall ----
    pulse_start();
    expect_evt(0, 0, 416);
    tick_n(16);
    tick_n(20);
    chk("pre_fall_y", int'(duck_y), 376);
    pulse_hit();
    tick_n(1);
    chk("falling_y", int'(duck_y), 380);
    chk("falling_flag", int'(duck_falling), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midfall_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_rng_en", int'(rng_enable), 1);
    chk("post_reset_busy", int'(busy), 0);
    pulse_start();
    chk("post_reset_start_busy", int'(busy), 1);
    tick_n(4);
    chk("pending_expectations", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
